// File: rtl/prog_updown_counter.sv
// rtl/prog_updown_counter.sv - loadable up/down counter with modulus, prescaler, wrap/saturate, tc and compare
module prog_updown_counter #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] max_val,
  input  logic [PSC_W-1:0] prescale,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             oe,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             cmp_match
);

  logic [WIDTH-1:0] cnt;
  logic [PSC_W-1:0] psc;
  logic             tc_q;
  logic             tick;
  logic             terminal;
  logic [WIDTH-1:0] cnt_next;

  // >= rather than == so that lowering prescale mid-period ticks on the next enabled cycle
  assign tick = en && (psc >= prescale);

  always_comb begin
    terminal = 1'b0;
    cnt_next = cnt;
    if (up) begin
      terminal = (cnt >= max_val);
      if (!terminal)  cnt_next = cnt + 1'b1;
      else if (sat)   cnt_next = max_val;
      else            cnt_next = '0;
    end else begin
      terminal = (cnt == '0);
      if (!terminal)  cnt_next = cnt - 1'b1;
      else if (sat)   cnt_next = '0;
      else            cnt_next = max_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      psc  <= '0;
      tc_q <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      psc  <= '0;
      tc_q <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (tick) begin
        psc  <= '0;
        cnt  <= cnt_next;
        tc_q <= terminal;
      end else if (en) begin
        psc <= psc + 1'b1;
      end
    end
  end

  assign count_out = oe ? cnt : '0;
  assign tc        = tc_q;
  assign cmp_match = (cnt == cmp_val);

endmodule

// File: tb/tb_prog_updown_counter.sv
// tb/tb_prog_updown_counter.sv - directed self-checking bench for prog_updown_counter
module tb_prog_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, load, up, sat, oe;
  logic [7:0] load_val, max_val, cmp_val;
  logic [3:0] prescale;
  logic [7:0] count_out;
  logic       tc, cmp_match;

  int n_checks = 0;
  int n_fail   = 0;

  prog_updown_counter #(.WIDTH(8), .PSC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .up(up), .sat(sat), .max_val(max_val), .prescale(prescale),
    .cmp_val(cmp_val), .oe(oe), .count_out(count_out), .tc(tc),
    .cmp_match(cmp_match)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; en = 1'b1; oe = 1'b1; cmp_val = 8'h00;
    step(); step();
    n_checks++; if (count_out !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", count_out); end
    n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", tc); end
    n_checks++; if (cmp_match !== 1'b1) begin n_fail++; $display("FAIL reset_cmp: got %b want 1", cmp_match); end
    rst_n = 1'b1; en = 1'b0;
  endtask

  task automatic test_load_oe();
    oe = 1'b1;
    do_load(8'hA5);
    n_checks++; if (count_out !== 8'hA5) begin n_fail++; $display("FAIL load_a5: got %h want a5", count_out); end
    oe = 1'b0; cmp_val = 8'hA5; #1;
    n_checks++; if (count_out !== 8'h00) begin n_fail++; $display("FAIL oe_off: got %h want 00", count_out); end
    n_checks++; if (cmp_match !== 1'b1) begin n_fail++; $display("FAIL cmp_ungated: got %b want 1", cmp_match); end
    step(); oe = 1'b1; #1;
    n_checks++; if (count_out !== 8'hA5) begin n_fail++; $display("FAIL oe_retain: got %h want a5", count_out); end
  endtask

  task automatic test_wrap_up();
    logic [7:0] ec;
    max_val = 8'd9; up = 1'b1; sat = 1'b0; prescale = 4'd0; cmp_val = 8'd5; en = 1'b0;
    do_load(8'd0);
    en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      ec = 8'(i % 10);
      n_checks++; if (count_out !== ec) begin n_fail++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", i, count_out, ec); end
      n_checks++; if (tc !== (i == 10)) begin n_fail++; $display("FAIL wrap_tc[%0d]: got %b want %b", i, tc, i == 10); end
      n_checks++; if (cmp_match !== (ec == 8'd5)) begin n_fail++; $display("FAIL wrap_cmp[%0d]: got %b want %b", i, cmp_match, ec == 8'd5); end
    end
    en = 1'b0;
  endtask

  task automatic test_sat_down();
    logic [7:0] exp_c [7] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
    logic       exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    max_val = 8'd9; up = 1'b0; sat = 1'b1; prescale = 4'd0; cmp_val = 8'hFF;
    do_load(8'd3);
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) up = 1'b1;
      step();
      n_checks++; if (count_out !== exp_c[i]) begin n_fail++; $display("FAIL satdn_cnt[%0d]: got %0d want %0d", i, count_out, exp_c[i]); end
      n_checks++; if (tc !== exp_t[i]) begin n_fail++; $display("FAIL satdn_tc[%0d]: got %b want %b", i, tc, exp_t[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_prescaler();
    logic [7:0] exp_c [6] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
    logic       exp_e [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    max_val = 8'd9; up = 1'b1; sat = 1'b0; prescale = 4'd3;
    do_load(8'd0);
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_checks++; if (count_out !== 8'(i / 4)) begin n_fail++; $display("FAIL psc_cnt[%0d]: got %0d want %0d", i, count_out, i / 4); end
    end
    // en dropped for two cycles mid-period: the step lands two cycles late
    for (int i = 0; i < 6; i++) begin
      en = exp_e[i];
      step();
      n_checks++; if (count_out !== exp_c[i]) begin n_fail++; $display("FAIL psc_stretch[%0d]: got %0d want %0d", i, count_out, exp_c[i]); end
    end
    en = 1'b1;
    step(); step();
    n_checks++; if (count_out !== 8'd3) begin n_fail++; $display("FAIL psc_pre_change: got %0d want 3", count_out); end
    prescale = 4'd0;
    step();
    n_checks++; if (count_out !== 8'd4) begin n_fail++; $display("FAIL psc_lowered: got %0d want 4", count_out); end
    en = 1'b0;
  endtask

  task automatic test_boundaries();
    prescale = 4'd0; up = 1'b1; en = 1'b0;
    max_val = 8'd100; sat = 1'b0;
    do_load(8'd200);
    n_checks++; if (count_out !== 8'd200) begin n_fail++; $display("FAIL oor_load: got %0d want 200", count_out); end
    en = 1'b1; step(); en = 1'b0;
    n_checks++; if (count_out !== 8'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL oor_wrap: got %0d/%b want 0/1", count_out, tc); end
    sat = 1'b1;
    do_load(8'd200);
    en = 1'b1; step(); en = 1'b0;
    n_checks++; if (count_out !== 8'd100 || tc !== 1'b1) begin n_fail++; $display("FAIL oor_sat: got %0d/%b want 100/1", count_out, tc); end
    max_val = 8'd0;
    do_load(8'd0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sat = i[0]; up = i[1];
      step();
      n_checks++; if (count_out !== 8'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL max0[%0d]: got %0d/%b want 0/1", i, count_out, tc); end
    end
    en = 1'b0; max_val = 8'd255; up = 1'b1; sat = 1'b0;
    do_load(8'd254);
    en = 1'b1;
    step();
    n_checks++; if (count_out !== 8'd255 || tc !== 1'b0) begin n_fail++; $display("FAIL full_255: got %0d/%b want 255/0", count_out, tc); end
    step();
    n_checks++; if (count_out !== 8'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL full_wrap: got %0d/%b want 0/1", count_out, tc); end
    en = 1'b0;
  endtask

  task automatic test_collisions();
    max_val = 8'd9; up = 1'b1; sat = 1'b0; prescale = 4'd0; en = 1'b0;
    do_load(8'd9);
    en = 1'b1; load = 1'b1; load_val = 8'd4;
    step();
    load = 1'b0; en = 1'b0;
    n_checks++; if (count_out !== 8'd4 || tc !== 1'b0) begin n_fail++; $display("FAIL load_vs_tick: got %0d/%b want 4/0", count_out, tc); end
    // psc must have been cleared by the load: first tick on the third enabled cycle
    prescale = 4'd2; en = 1'b1;
    step(); step();
    n_checks++; if (count_out !== 8'd4) begin n_fail++; $display("FAIL load_psc_clr_a: got %0d want 4", count_out); end
    step();
    n_checks++; if (count_out !== 8'd5) begin n_fail++; $display("FAIL load_psc_clr_b: got %0d want 5", count_out); end
    rst_n = 1'b0; load = 1'b1; load_val = 8'h55; cmp_val = 8'h00;
    step();
    load = 1'b0;
    n_checks++; if (count_out !== 8'd0 || cmp_match !== 1'b1) begin n_fail++; $display("FAIL rst_vs_load: got %0d/%b want 0/1", count_out, cmp_match); end
    rst_n = 1'b1; prescale = 4'd3; en = 1'b1;
    step(); step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++; if (count_out !== 8'(i / 4)) begin n_fail++; $display("FAIL rst_mid_psc[%0d]: got %0d want %0d", i, count_out, i / 4); end
    end
    en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; up = 1'b1; sat = 1'b0;
    max_val = 8'd9; prescale = '0; cmp_val = '0; oe = 1'b1;
    test_reset();
    test_load_oe();
    test_wrap_up();
    test_sat_down();
    test_prescaler();
    test_boundaries();
    test_collisions();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
